// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control unit.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, handshaking
// with instruction fetch (instr_valid) and data memory (mem_ready). It drives
// the datapath strobes and reports sticky illegal-opcode and memory-timeout
// status.
// Instruction word layout: {opcode[3:0], rsel[RSEL_W-1:0], operand[ADDR_W-1:0]}.

module multicycle_ctrl_fsm #(
    parameter int RSEL_W       = 1,
    parameter int ADDR_W       = 4,
    parameter int MEM_TIMEOUT  = 15,
    parameter int ILLEGAL_HALT = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid,
    input  logic [4+RSEL_W+ADDR_W-1:0]   instr,
    input  logic                         mem_ready,
    output logic                         fetch_req,
    output logic                         reg_write,
    output logic [RSEL_W-1:0]            reg_sel,
    output logic [2:0]                   alu_op,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         pc_inc,
    output logic                         halt,
    output logic                         illegal,
    output logic                         fault
);

    localparam int IR_W    = 4 + RSEL_W + ADDR_W;
    localparam int OPC_LSB = RSEL_W + ADDR_W;

    // The wait counter only needs to count up to MEM_TIMEOUT-1.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    localparam logic [3:0] OPC_NOP   = 4'b0000;
    localparam logic [3:0] OPC_LOAD  = 4'b0001;
    localparam logic [3:0] OPC_STORE = 4'b0010;
    localparam logic [3:0] OPC_ADD   = 4'b0011;
    localparam logic [3:0] OPC_SUB   = 4'b0100;
    localparam logic [3:0] OPC_AND   = 4'b0101;
    localparam logic [3:0] OPC_OR    = 4'b0110;
    localparam logic [3:0] OPC_HALT  = 4'b1111;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NOP     = 3'd0,
        C_LOAD    = 3'd1,
        C_STORE   = 3'd2,
        C_ALU     = 3'd3,
        C_HALT    = 3'd4,
        C_ILLEGAL = 3'd5
    } class_t;

    state_t            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    class_t            cls_q, cls_d;
    logic [2:0]        alu_code_q, alu_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic              fault_q, fault_d;

    logic [3:0]        ir_opcode;
    logic [RSEL_W-1:0] ir_rsel;
    logic [ADDR_W-1:0] ir_operand;

    assign ir_opcode  = ir_q[IR_W-1 -: 4];
    assign ir_rsel    = ir_q[OPC_LSB-1 -: RSEL_W];
    assign ir_operand = ir_q[ADDR_W-1:0];

    // State, instruction register, decoded class and sticky status flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            cls_q      <= C_NOP;
            alu_code_q <= ALU_NONE;
            cnt_q      <= '0;
            illegal_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            cls_q      <= cls_d;
            alu_code_q <= alu_code_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state logic: instruction latch, opcode classification, memory wait timeout.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        cls_d      = cls_q;
        alu_code_d = alu_code_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;
        fault_d    = fault_q;

        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                alu_code_d = ALU_NONE;
                case (ir_opcode)
                    OPC_NOP:   cls_d = C_NOP;
                    OPC_LOAD:  cls_d = C_LOAD;
                    OPC_STORE: cls_d = C_STORE;
                    OPC_ADD: begin
                        cls_d      = C_ALU;
                        alu_code_d = ALU_ADD;
                    end
                    OPC_SUB: begin
                        cls_d      = C_ALU;
                        alu_code_d = ALU_SUB;
                    end
                    OPC_AND: begin
                        cls_d      = C_ALU;
                        alu_code_d = ALU_AND;
                    end
                    OPC_OR: begin
                        cls_d      = C_ALU;
                        alu_code_d = ALU_OR;
                    end
                    OPC_HALT:  cls_d = C_HALT;
                    default:   cls_d = C_ILLEGAL;
                endcase
                state_d = S_EXEC;
            end

            S_EXEC: begin
                case (cls_q)
                    C_NOP:   state_d = S_FETCH;
                    C_ALU:   state_d = S_WB;
                    C_LOAD,
                    C_STORE: begin
                        cnt_d   = '0;
                        state_d = S_MEM;
                    end
                    C_HALT:  state_d = S_HALTED;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = (ILLEGAL_HALT != 0) ? S_HALTED : S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                end else if (MEM_TIMEOUT != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        fault_d = 1'b1;
                        state_d = S_HALTED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_WB: begin
                state_d = S_FETCH;
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output decode from state and latched IR; pc_inc for STORE follows mem_ready so it pulses in the completing MEM cycle.
    always_comb begin
        fetch_req = 1'b0;
        reg_write = 1'b0;
        reg_sel   = '0;
        alu_op    = ALU_NONE;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        pc_inc    = 1'b0;
        halt      = 1'b0;

        if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            reg_sel  = ir_rsel;
            mem_addr = ir_operand;
        end

        case (state_q)
            S_FETCH: begin
                // Gated by rst_n so every output reads 0 while reset is held.
                fetch_req = rst_n;
            end

            S_EXEC: begin
                if (cls_q == C_ALU) begin
                    alu_op = alu_code_q;
                end
                if (cls_q == C_NOP || (cls_q == C_ILLEGAL && ILLEGAL_HALT == 0)) begin
                    pc_inc = 1'b1;
                end
            end

            S_MEM: begin
                mem_read  = (cls_q == C_LOAD);
                mem_write = (cls_q == C_STORE);
                pc_inc    = (cls_q == C_STORE) && mem_ready;
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_inc    = 1'b1;
                if (cls_q == C_ALU) begin
                    alu_op = alu_code_q;
                end
            end

            S_HALTED: begin
                halt = 1'b1;
            end

            default: begin
            end
        endcase
    end

    assign illegal = illegal_q;
    assign fault   = fault_q;

    a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({reg_write, mem_read, mem_write}));

    a_halt_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        halt |-> !(fetch_req || pc_inc || reg_write || mem_read || mem_write));

endmodule
